// File: rtl/ctrl_pipe_tracker.sv
// Carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB, inserting
// bubbles on load-use hazards and ID flushes, and drives the EX forwarding selects.
module ctrl_pipe_tracker #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_alu_src,
   input  logic [1:0]        id_alu_op,
   input  logic              id_reg_dst,
   input  logic              id_mem_write,
   input  logic              id_mem_read,
   input  logic              id_mem_to_reg,
   input  logic              id_reg_write,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              flush_id,
   output logic              stall,
   output logic              ex_alu_src,
   output logic [1:0]        ex_alu_op,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic              mem_mem_write,
   output logic              mem_mem_read,
   output logic [REG_AW-1:0] mem_dest,
   output logic              wb_mem_to_reg,
   output logic              wb_reg_write,
   output logic [REG_AW-1:0] wb_dest,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_count
);

   logic              ex_mem_write;
   logic              ex_mem_read;
   logic              ex_mem_to_reg;
   logic              ex_reg_write;
   logic [REG_AW-1:0] ex_dest;
   logic              mem_mem_to_reg;
   logic              mem_reg_write;
   logic              load_use;
   logic              bubble;

   // EX/MEM wins over MEM/WB because it holds the younger write; r0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              m_we,
      input logic [REG_AW-1:0] m_dst,
      input logic              w_we,
      input logic [REG_AW-1:0] w_dst
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_dst != '0) && (m_dst == src))
         sel = 2'b10;
      else if (w_we && (w_dst != '0) && (w_dst == src))
         sel = 2'b01;
      return sel;
   endfunction

   assign load_use = id_valid & ex_mem_read & (ex_dest != '0) &
                     ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));

   // A flushed ID instruction is discarded anyway, so it needs no hold, only the bubble.
   assign stall  = load_use & ~flush_id;
   assign bubble = ~id_valid | flush_id | load_use;

   assign fwd_a = fwd_sel(ex_rs, mem_reg_write, mem_dest, wb_reg_write, wb_dest);
   assign fwd_b = fwd_sel(ex_rt, mem_reg_write, mem_dest, wb_reg_write, wb_dest);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_alu_src    <= 1'b0;
         ex_alu_op     <= 2'b00;
         ex_mem_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_dest       <= '0;
      end else if (bubble) begin
         ex_alu_src    <= 1'b0;
         ex_alu_op     <= 2'b00;
         ex_mem_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_dest       <= '0;
      end else begin
         ex_alu_src    <= id_alu_src;
         ex_alu_op     <= id_alu_op;
         ex_mem_write  <= id_mem_write;
         ex_mem_read   <= id_mem_read;
         ex_mem_to_reg <= id_mem_to_reg;
         ex_reg_write  <= id_reg_write;
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_dest       <= id_reg_dst ? id_rd : id_rt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_mem_write  <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_dest       <= '0;
         wb_mem_to_reg  <= 1'b0;
         wb_reg_write   <= 1'b0;
         wb_dest        <= '0;
      end else begin
         mem_mem_write  <= ex_mem_write;
         mem_mem_read   <= ex_mem_read;
         mem_mem_to_reg <= ex_mem_to_reg;
         mem_reg_write  <= ex_reg_write;
         mem_dest       <= ex_dest;
         wb_mem_to_reg  <= mem_mem_to_reg;
         wb_reg_write   <= mem_reg_write;
         wb_dest        <= mem_dest;
      end
   end

   // Saturating: holds at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_count <= '0;
      else if (stall && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// Bench for ctrl_pipe_tracker: directed hazard/forwarding scenarios plus a random
// back-to-back stream checked through per-stage expected queues.
module tb_ctrl_pipe_tracker;

   localparam int AW = 5;
   localparam int CW = 3;
   localparam int EW = 22;
   localparam int K_R   = 0;
   localparam int K_LW  = 1;
   localparam int K_SW  = 2;
   localparam int K_NOP = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0, id_alu_src = 1'b0, id_reg_dst = 1'b0;
   logic [1:0]    id_alu_op = 2'b00;
   logic          id_mem_write = 1'b0, id_mem_read = 1'b0, id_mem_to_reg = 1'b0, id_reg_write = 1'b0;
   logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0;
   logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic          flush_id = 1'b0;
   logic          stall, ex_alu_src, mem_mem_write, mem_mem_read, wb_mem_to_reg, wb_reg_write;
   logic [1:0]    ex_alu_op, fwd_a, fwd_b;
   logic [AW-1:0] ex_rs, ex_rt, mem_dest, wb_dest;
   logic [CW-1:0] stall_count;
   logic [34:0]   all_out;

   // entry: [21]mem_write [20]mem_read [19]mem_to_reg [18]reg_write [17]alu_src [16:15]alu_op
   //        [14:10]rs [9:5]rt [4:0]dest
   logic [EW-1:0] ex_q[$];
   logic [EW-1:0] mem_q[$];
   logic [EW-1:0] wb_q[$];
   logic [EW-1:0] e;
   int checks = 0;
   int failures = 0;

   ctrl_pipe_tracker #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .id_reg_dst(id_reg_dst), .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
      .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write), .id_uses_rs(id_uses_rs),
      .id_uses_rt(id_uses_rt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush_id(flush_id),
      .stall(stall), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .mem_mem_write(mem_mem_write), .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
   );

   assign all_out = {stall, ex_alu_src, ex_alu_op, ex_rs, ex_rt, mem_mem_write, mem_mem_read,
                     mem_dest, wb_mem_to_reg, wb_reg_write, wb_dest, fwd_a, fwd_b, stall_count};

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // driver tasks
   function automatic logic [EW-1:0] make_entry(input int kind, input logic [AW-1:0] rs,
                                                input logic [AW-1:0] rt, input logic [AW-1:0] rd);
      case (kind)
         K_R:     return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, rs, rt, rd};
         K_LW:    return {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, rs, rt, rt};
         K_SW:    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, rs, rt, rt};
         default: return '0;
      endcase
   endfunction

   task automatic drive(input int kind, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd);
      id_valid      = (kind != K_NOP);
      id_alu_src    = (kind == K_LW) || (kind == K_SW);
      id_alu_op     = (kind == K_R) ? 2'b10 : 2'b00;
      id_reg_dst    = (kind == K_R);
      id_mem_write  = (kind == K_SW);
      id_mem_read   = (kind == K_LW);
      id_mem_to_reg = (kind == K_LW);
      id_reg_write  = (kind == K_R) || (kind == K_LW);
      id_uses_rs    = (kind != K_NOP);
      id_uses_rt    = (kind == K_R) || (kind == K_SW);
      id_rs         = (kind == K_NOP) ? '0 : rs;
      id_rt         = (kind == K_NOP) ? '0 : rt;
      id_rd         = (kind == K_NOP) ? '0 : rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      flush_id = 1'b0;
      drive(K_NOP, 0, 0, 0);
      rst = 1'b1;
      #4;
      rst = 1'b0;
      ex_q.delete();
      mem_q.delete();
      wb_q.delete();
   endtask

   // tests
   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (all_out !== 35'd0) begin
         failures++;
         $display("FAIL reset_state: got=%h want=0", all_out);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      drive(K_LW, 2, 8, 0);
      tick();
      drive(K_R, 4, 5, 6);
      tick();
      drive(K_NOP, 0, 0, 0);
      checks++;
      if ({mem_mem_read, mem_dest, ex_alu_op, ex_rs} !== {1'b1, 5'd8, 2'b10, 5'd4}) begin
         failures++;
         $display("FAIL pre_reset_pipe: got=%h want=%h", {mem_mem_read, mem_dest, ex_alu_op, ex_rs},
                  {1'b1, 5'd8, 2'b10, 5'd4});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (all_out !== 35'd0) begin
         failures++;
         $display("FAIL async_reset: got=%h want=0", all_out);
      end
      drive(K_R, 1, 2, 3);
      #1 rst = 1'b0;
      tick();
      checks++;
      if ({ex_alu_src, ex_alu_op, ex_rs, ex_rt, mem_mem_read} !== {1'b0, 2'b10, 5'd1, 5'd2, 1'b0}) begin
         failures++;
         $display("FAIL post_reset_load: got=%h want=%h", {ex_alu_src, ex_alu_op, ex_rs, ex_rt, mem_mem_read},
                  {1'b0, 2'b10, 5'd1, 5'd2, 1'b0});
      end
      drive(K_NOP, 0, 0, 0);
   endtask

   task automatic test_load_use();
      do_reset();
      drive(K_LW, 2, 8, 0);
      ex_q.push_back(make_entry(K_LW, 2, 8, 0));
      tick();
      e = ex_q.pop_front();
      checks++;
      if ({ex_alu_src, ex_alu_op, ex_rs, ex_rt} !== e[17:5]) begin
         failures++;
         $display("FAIL lu_ex_lw: got=%h want=%h", {ex_alu_src, ex_alu_op, ex_rs, ex_rt}, e[17:5]);
      end
      drive(K_R, 8, 1, 9);
      ex_q.push_back('0);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL lu_stall_on: got=%b want=1", stall);
      end
      tick();
      e = ex_q.pop_front();
      checks++;
      if ({ex_alu_src, ex_alu_op, ex_rs, ex_rt, mem_mem_read, mem_dest, stall_count} !==
          {e[17:5], 1'b1, 5'd8, 3'd1}) begin
         failures++;
         $display("FAIL lu_bubble: got=%h want=%h",
                  {ex_alu_src, ex_alu_op, ex_rs, ex_rt, mem_mem_read, mem_dest, stall_count},
                  {e[17:5], 1'b1, 5'd8, 3'd1});
      end
      ex_q.push_back(make_entry(K_R, 8, 1, 9));
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL lu_stall_one_cycle: got=%b want=0", stall);
      end
      tick();
      e = ex_q.pop_front();
      checks++;
      if ({ex_alu_op, ex_rs, ex_rt, fwd_a, fwd_b, wb_mem_to_reg, wb_reg_write, wb_dest, stall_count} !==
          {e[16:5], 2'b01, 2'b00, 1'b1, 1'b1, 5'd8, 3'd1}) begin
         failures++;
         $display("FAIL lu_retry_fwd: got=%h want=%h",
                  {ex_alu_op, ex_rs, ex_rt, fwd_a, fwd_b, wb_mem_to_reg, wb_reg_write, wb_dest, stall_count},
                  {e[16:5], 2'b01, 2'b00, 1'b1, 1'b1, 5'd8, 3'd1});
      end
      drive(K_NOP, 0, 0, 0);
   endtask

   task automatic test_forwarding();
      logic [1:0] want [3];
      want[0] = 2'b10;
      want[1] = 2'b01;
      want[2] = 2'b10;
      for (int s = 0; s < 3; s++) begin
         do_reset();
         drive(K_R, 1, 2, 3);
         tick();
         if (s == 1) begin
            drive(K_R, 1, 2, 5);
            tick();
         end else if (s == 2) begin
            drive(K_R, 2, 1, 3);
            tick();
         end
         drive(K_R, 3, 3, 4);
         #1;
         checks++;
         if (stall !== 1'b0) begin
            failures++;
            $display("FAIL fwd_no_stall_%0d: got=%b want=0", s, stall);
         end
         tick();
         checks++;
         if ({fwd_a, fwd_b} !== {want[s], want[s]}) begin
            failures++;
            $display("FAIL fwd_case_%0d: got=%b_%b want=%b_%b", s, fwd_a, fwd_b, want[s], want[s]);
         end
         drive(K_NOP, 0, 0, 0);
      end
   endtask

   task automatic test_reg_zero();
      do_reset();
      drive(K_R, 1, 2, 0);
      tick();
      drive(K_R, 0, 0, 6);
      tick();
      checks++;
      if ({fwd_a, fwd_b, mem_dest} !== {2'b00, 2'b00, 5'd0}) begin
         failures++;
         $display("FAIL r0_no_fwd: got=%h want=0", {fwd_a, fwd_b, mem_dest});
      end
      drive(K_LW, 2, 0, 0);
      tick();
      drive(K_R, 0, 1, 7);
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL r0_no_stall: got=%b want=0", stall);
      end
      tick();
      checks++;
      if ({ex_alu_op, ex_rs, ex_rt, stall_count} !== {2'b10, 5'd0, 5'd1, 3'd0}) begin
         failures++;
         $display("FAIL r0_no_bubble: got=%h want=%h", {ex_alu_op, ex_rs, ex_rt, stall_count},
                  {2'b10, 5'd0, 5'd1, 3'd0});
      end
      drive(K_NOP, 0, 0, 0);
   endtask

   task automatic test_flush();
      do_reset();
      drive(K_SW, 1, 2, 3);
      flush_id = 1'b1;
      tick();
      flush_id = 1'b0;
      drive(K_NOP, 0, 0, 0);
      checks++;
      if ({ex_alu_src, ex_alu_op, ex_rs, ex_rt} !== 13'd0) begin
         failures++;
         $display("FAIL flush_bubble: got=%h want=0", {ex_alu_src, ex_alu_op, ex_rs, ex_rt});
      end
      tick();
      checks++;
      if ({mem_mem_write, mem_dest} !== 6'd0) begin
         failures++;
         $display("FAIL flush_mem_clear: got=%h want=0", {mem_mem_write, mem_dest});
      end
      drive(K_LW, 2, 8, 0);
      tick();
      drive(K_R, 8, 1, 9);
      flush_id = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL flush_lu_stall: got=%b want=0", stall);
      end
      tick();
      flush_id = 1'b0;
      drive(K_NOP, 0, 0, 0);
      checks++;
      if ({ex_alu_op, ex_rs, ex_rt, mem_mem_read, stall_count} !== {2'b00, 5'd0, 5'd0, 1'b1, 3'd0}) begin
         failures++;
         $display("FAIL flush_lu_bubble: got=%h want=%h", {ex_alu_op, ex_rs, ex_rt, mem_mem_read, stall_count},
                  {2'b00, 5'd0, 5'd0, 1'b1, 3'd0});
      end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] want;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(K_LW, 2, 8, 0);
         tick();
         drive(K_R, 8, 1, 9);
         #1;
         checks++;
         if (stall !== 1'b1) begin
            failures++;
            $display("FAIL sat_stall_%0d: got=%b want=1", i, stall);
         end
         tick();
         want = (i + 1 > 7) ? CW'(7) : CW'(i + 1);
         checks++;
         if (stall_count !== want) begin
            failures++;
            $display("FAIL sat_count_%0d: got=%0d want=%0d", i, stall_count, want);
         end
         tick();
      end
      drive(K_NOP, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      int r, kind;
      logic [AW-1:0] rs, rt, rd;
      do_reset();
      for (int c = 0; c < 40; c++) begin
         r = $urandom_range(0, 2);
         kind = (r == 0) ? K_R : ((r == 1) ? K_SW : K_NOP);
         rs = AW'($urandom_range(0, 31));
         rt = AW'($urandom_range(0, 31));
         rd = AW'($urandom_range(0, 31));
         drive(kind, rs, rt, rd);
         ex_q.push_back(make_entry(kind, rs, rt, rd));
         tick();
         if (wb_q.size() > 0) begin
            e = wb_q.pop_front();
            checks++;
            if ({wb_mem_to_reg, wb_reg_write, wb_dest} !== {e[19], e[18], e[4:0]}) begin
               failures++;
               $display("FAIL b2b_wb_%0d: got=%h want=%h", c, {wb_mem_to_reg, wb_reg_write, wb_dest},
                        {e[19], e[18], e[4:0]});
            end
         end
         if (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            checks++;
            if ({mem_mem_write, mem_mem_read, mem_dest} !== {e[21], e[20], e[4:0]}) begin
               failures++;
               $display("FAIL b2b_mem_%0d: got=%h want=%h", c, {mem_mem_write, mem_mem_read, mem_dest},
                        {e[21], e[20], e[4:0]});
            end
            wb_q.push_back(e);
         end
         e = ex_q.pop_front();
         checks++;
         if ({ex_alu_src, ex_alu_op, ex_rs, ex_rt, stall} !== {e[17:5], 1'b0}) begin
            failures++;
            $display("FAIL b2b_ex_%0d: got=%h want=%h", c, {ex_alu_src, ex_alu_op, ex_rs, ex_rt, stall},
                     {e[17:5], 1'b0});
         end
         mem_q.push_back(e);
      end
      drive(K_NOP, 0, 0, 0);
   endtask

   // sequence and final report
   initial begin
      test_reset();
      test_reset_midstream();
      test_load_use();
      test_forwarding();
      test_reg_zero();
      test_flush();
      test_saturation();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
